// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer at a time the FIFO write
// port for up to MaxBurst beats or until that producer's packet ends.
//
// state | meaning
// IDLE  | no owner; pick the next valid producer after lastGrant
// BURST | grantId owns the write port; beats pass while !full
module fifo_wr_arbiter #(
  parameter int DataWidth = 32,
  parameter int NumReq    = 4,
  parameter int MaxBurst  = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NumReq-1:0]           reqValid,
  input  logic [NumReq*DataWidth-1:0] reqData,
  input  logic [NumReq-1:0]           reqLast,
  output logic [NumReq-1:0]           reqReady,
  output logic                        writeEn,
  output logic [DataWidth-1:0]        writeData,
  input  logic                        full,
  output logic                        grantValid,
  output logic [$clog2(NumReq)-1:0]   grantId
);

  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = $clog2(MaxBurst) + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t               state, state_nxt;
  logic [IdW-1:0]       grant_id, grant_nxt;
  logic [IdW-1:0]       last_grant, last_nxt;
  logic [CntW-1:0]      beat_cnt, cnt_nxt;
  logic [IdW-1:0]       pick;
  logic                 found;
  logic                 burst, beat;
  logic                 sel_valid, sel_last;
  logic [DataWidth-1:0] sel_data;

  // Search upward from lastGrant+1, wrapping at NumReq.
  always_comb begin : p_pick
    int cand;
    pick  = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NumReq; k++) begin
      cand = int'(last_grant) + k;
      if (cand >= NumReq) cand = cand - NumReq;
      for (int i = 0; i < NumReq; i++) begin
        if (!found && (i == cand) && reqValid[i]) begin
          pick  = IdW'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (grant_id == IdW'(i)) begin
        sel_valid = reqValid[i];
        sel_last  = reqLast[i];
        sel_data  = reqData[i*DataWidth +: DataWidth];
      end
    end
  end

  // Outputs are gated by rst so an aborted burst writes nothing in the reset cycle.
  assign burst = (state == BURST) && !rst;
  assign beat  = burst && sel_valid && !full;

  always_comb begin
    reqReady = '0;
    for (int i = 0; i < NumReq; i++) begin
      reqReady[i] = burst && !full && (grant_id == IdW'(i));
    end
  end

  assign writeEn    = beat;
  assign writeData  = burst ? sel_data : '0;
  assign grantValid = burst;
  assign grantId    = grant_id;

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_grant;
    cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          cnt_nxt   = '0;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (beat) begin
          cnt_nxt = beat_cnt + CntW'(1);
          if (sel_last || (cnt_nxt == CntW'(MaxBurst))) begin
            state_nxt = IDLE;
            last_nxt  = grant_id;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IdW'(NumReq - 1);
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_nxt;
      beat_cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed multi-cycle sequences and
// randomized traffic against a transaction-level producer/arbiter model.
module tb_fifo_wr_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NR-1:0]     reqValid = '0;
  logic [NR*DW-1:0]  reqData = '0;
  logic [NR-1:0]     reqLast = '0;
  logic [NR-1:0]     reqReady;
  logic              writeEn;
  logic [DW-1:0]     writeData;
  logic              full = 1'b0;
  logic              grantValid;
  logic [1:0]        grantId;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.DataWidth(DW), .NumReq(NR), .MaxBurst(MB)) dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqData(reqData), .reqLast(reqLast),
    .reqReady(reqReady), .writeEn(writeEn), .writeData(writeData), .full(full),
    .grantValid(grantValid), .grantId(grantId)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cycle-level invariants, always on once the first edge has passed.
  bit prop_on = 1'b0;
  always @(negedge clk) begin
    if (prop_on) begin
      if (rst) begin
        check("rst_outputs_zero", {writeEn, grantValid, reqReady, writeData}, 64'd0);
      end else begin
        check("ready_onehot0", 64'($onehot0(reqReady)), 64'd1);
        check("no_write_when_full", 64'(writeEn && full), 64'd0);
        check("we_is_handshake", 64'(writeEn), 64'(|(reqValid & reqReady)));
      end
    end
  end

  // Producer side: one queue of {last, data} words per producer.
  logic [32:0]   wq [NR][$];
  int            seq [NR];
  logic [NR-1:0] en = '1;
  bit            rnd_mode = 1'b0;

  function automatic logic [31:0] mk(input int p, input int n);
    return {8'(p), 24'(n)};
  endfunction

  task automatic load(input int p, input int len);
    for (int j = 0; j < len; j++) begin
      wq[p].push_back({(j == len - 1), mk(p, seq[p])});
      seq[p]++;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (wq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (wq[i].size() > 0) begin
        reqValid[i]          = en[i];
        reqData[i*DW +: DW]  = wq[i][0][31:0];
        reqLast[i]           = wq[i][0][32];
      end else begin
        reqValid[i]          = 1'b0;
        reqData[i*DW +: DW]  = $urandom;
        reqLast[i]           = 1'($urandom);
      end
    end
  endtask

  // Arbiter reference: owner (-1 when nobody), beats served, previous owner.
  int m_owner = -1;
  int m_last  = NR - 1;
  int m_beats = 0;

  task automatic model_cycle();
    logic        e_gv, e_we;
    logic [3:0]  e_rdy;
    logic [31:0] e_wd;
    e_gv  = !rst && (m_owner >= 0);
    e_rdy = '0;
    e_we  = 1'b0;
    e_wd  = '0;
    if (e_gv) begin
      if (!full) e_rdy = 4'(1 << m_owner);
      e_we = reqValid[m_owner] && !full;
      e_wd = reqData[m_owner*DW +: DW];
    end
    check("model_grantValid", 64'(grantValid), 64'(e_gv));
    check("model_reqReady", 64'(reqReady), 64'(e_rdy));
    check("model_writeEn", 64'(writeEn), 64'(e_we));
    check("model_writeData", 64'(writeData), 64'(e_wd));
    if (e_gv) check("model_grantId", 64'(grantId), 64'(m_owner));
    if (rst) begin
      m_owner = -1;
      m_last  = NR - 1;
      m_beats = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        if (m_owner < 0 && reqValid[(m_last + k) % NR]) begin
          m_owner = (m_last + k) % NR;
          m_beats = 0;
        end
      end
    end else if (e_we) begin
      m_beats++;
      if (reqLast[m_owner] || m_beats == MB) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  logic        s_gv, s_we, prev_gv = 1'b0;
  logic [1:0]  s_gid;
  logic [3:0]  s_rdy;
  logic [31:0] s_wd;
  int          glog[$];
  logic [31:0] wlog[$];
  int          eg[$];
  logic [31:0] ew[$];

  task automatic step();
    logic [NR-1:0] hs;
    drive();
    @(negedge clk);
    s_gv  = grantValid;
    s_we  = writeEn;
    s_gid = grantId;
    s_rdy = reqReady;
    s_wd  = writeData;
    model_cycle();
    if (s_gv && !prev_gv) glog.push_back(int'(s_gid));
    prev_gv = s_gv;
    if (s_we) wlog.push_back(s_wd);
    hs = reqValid & reqReady;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) void'(wq[i].pop_front());
  endtask

  task automatic reset_dut();
    for (int i = 0; i < NR; i++) begin
      wq[i].delete();
      seq[i] = 0;
    end
    en   = '1;
    full = 1'b0;
    rst  = 1'b1;
    step();
    step();
    rst = 1'b0;
    glog.delete();
    wlog.delete();
    eg.delete();
    ew.delete();
    prev_gv = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string nm);
    int n;
    n = 0;
    do begin
      if (rnd_mode) begin
        en   = NR'($urandom);
        full = ($urandom_range(0, 3) == 0);
      end
      step();
      n++;
    end while ((pending() || s_gv) && n < budget);
    full = 1'b0;
    en   = '1;
    check({nm, "_completes"}, 64'(n < budget), 64'd1);
  endtask

  task automatic cmp_glog(input string nm);
    check({nm, "_count"}, 64'(glog.size()), 64'(eg.size()));
    for (int i = 0; i < eg.size() && i < glog.size(); i++)
      check($sformatf("%s_%0d", nm, i), 64'(glog[i]), 64'(eg[i]));
  endtask

  task automatic cmp_wlog(input string nm);
    check({nm, "_count"}, 64'(wlog.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < wlog.size(); i++)
      check($sformatf("%s_%0d", nm, i), 64'(wlog[i]), 64'(ew[i]));
  endtask

  typedef struct {
    logic [3:0] v;
    logic       f;
    logic       gv;
    logic [1:0] gid;
    logic       we;
    logic [3:0] rdy;
  } vec_t;

  vec_t tv[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Out of reset the search starts at 0, so the lowest set bit wins.
    tv[0] = '{4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
    tv[1] = '{4'b0010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
    tv[2] = '{4'b0100, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000};
    tv[3] = '{4'b1000, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000};
    tv[4] = '{4'b0110, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
    tv[5] = '{4'b1100, 1'b1, 1'b1, 2'd2, 1'b0, 4'b0000};
    tv[6] = '{4'b1010, 1'b0, 1'b1, 2'd1, 1'b1, 4'b0010};
    tv[7] = '{4'b1111, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0001};
    tv[8] = '{4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    prop_on = 1'b1;

    for (int t = 0; t < 9; t++) begin
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      reqValid = tv[t].v;
      reqLast  = '1;
      full     = tv[t].f;
      for (int i = 0; i < NR; i++) reqData[i*DW +: DW] = mk(i, 100 + t);
      @(posedge clk);
      #1;
      @(negedge clk);
      check($sformatf("tbl%0d_grantValid", t), 64'(grantValid), 64'(tv[t].gv));
      check($sformatf("tbl%0d_grantId", t), 64'(grantId), 64'(tv[t].gid));
      check($sformatf("tbl%0d_writeEn", t), 64'(writeEn), 64'(tv[t].we));
      check($sformatf("tbl%0d_reqReady", t), 64'(reqReady), 64'(tv[t].rdy));
      check($sformatf("tbl%0d_writeData", t), 64'(writeData),
            tv[t].gv ? 64'(mk(int'(tv[t].gid), 100 + t)) : 64'd0);
      @(posedge clk);
      #1;
    end
    full = 1'b0;

    // Single 3-word packet from producer 0.
    reset_dut();
    load(0, 3);
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("pkt3_c%0d_grantValid", c + 1), 64'(s_gv), 64'(c >= 1 && c <= 3));
      check($sformatf("pkt3_c%0d_writeEn", c + 1), 64'(s_we), 64'(c >= 1 && c <= 3));
      if (c >= 1 && c <= 3)
        check($sformatf("pkt3_c%0d_data", c + 1), 64'(s_wd), 64'(mk(0, c - 1)));
    end

    // All producers busy with 1-word packets: strict rotation.
    reset_dut();
    for (int r = 0; r < 2; r++) for (int p = 0; p < NR; p++) load(p, 1);
    run_until_done(100, "rotate");
    for (int r = 0; r < 2; r++) for (int p = 0; p < NR; p++) eg.push_back(p);
    cmp_glog("rotate_grant");

    // Full stall in the middle of producer 2's burst.
    reset_dut();
    load(2, 4);
    repeat (3) step();
    full = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("stall%0d_writeEn", c), 64'(s_we), 64'd0);
      check($sformatf("stall%0d_reqReady", c), 64'(s_rdy), 64'd0);
      check($sformatf("stall%0d_grantId", c), 64'(s_gid), 64'd2);
      check($sformatf("stall%0d_grantValid", c), 64'(s_gv), 64'd1);
    end
    full = 1'b0;
    run_until_done(20, "stall");
    for (int n = 0; n < 4; n++) ew.push_back(mk(2, n));
    cmp_wlog("stall_data");

    // Producer 1 exceeds MaxBurst and finishes after the others are served.
    reset_dut();
    en = 4'b0010;
    load(1, 6);
    load(2, 1);
    load(3, 1);
    load(0, 1);
    step();
    en = '1;
    run_until_done(100, "split");
    eg.push_back(1); eg.push_back(2); eg.push_back(3); eg.push_back(0); eg.push_back(1);
    cmp_glog("split_grant");
    for (int n = 0; n < 4; n++) ew.push_back(mk(1, n));
    ew.push_back(mk(2, 0)); ew.push_back(mk(3, 0)); ew.push_back(mk(0, 0));
    ew.push_back(mk(1, 4)); ew.push_back(mk(1, 5));
    cmp_wlog("split_data");

    // Reset in the second beat aborts the burst; priority restarts at 0.
    reset_dut();
    load(2, 4);
    step();
    step();
    check("abort_beat1", 64'(s_we), 64'd1);
    rst = 1'b1;
    step();
    check("abort_rst_writeEn", 64'(s_we), 64'd0);
    rst = 1'b0;
    glog.delete();
    wlog.delete();
    prev_gv = 1'b0;
    load(0, 1);
    load(3, 1);
    run_until_done(50, "abort");
    eg.push_back(0); eg.push_back(2); eg.push_back(3);
    cmp_glog("abort_grant");
    ew.push_back(mk(0, 0));
    for (int n = 1; n < 4; n++) ew.push_back(mk(2, n));
    ew.push_back(mk(3, 0));
    cmp_wlog("abort_data");

    // Random traffic: stalls, full, long packets; per-producer order must hold.
    for (int round = 0; round < 4; round++) begin
      int total;
      int nxt[NR];
      reset_dut();
      total = 0;
      for (int p = 0; p < NR; p++) begin
        nxt[p] = 0;
        for (int k = 0; k < 4; k++) begin
          int len;
          len = $urandom_range(1, 7);
          load(p, len);
          total += len;
        end
      end
      rnd_mode = 1'b1;
      run_until_done(4000, $sformatf("rand%0d", round));
      rnd_mode = 1'b0;
      check($sformatf("rand%0d_words", round), 64'(wlog.size()), 64'(total));
      foreach (wlog[i]) begin
        int p;
        p = int'(wlog[i][31:24]);
        if (p < NR) begin
          check($sformatf("rand%0d_order_p%0d", round, p), 64'(wlog[i][23:0]), 64'(nxt[p]));
          nxt[p]++;
        end else begin
          check($sformatf("rand%0d_producer_id", round), 64'(p), 64'(NR - 1));
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
